// File: rtl/smc_addr_seq_pkg.sv
// Shared encodings for the SMC address sequencer: transfer/bus size codes,
// FSM states and the byte-lane mask helper used by the lane decoder.
package smc_addr_seq_pkg;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_64 = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int MAX_LANES = 8;

  // Active-high lane mask. A transfer wider than the bus uses every bus lane.
  // A narrow transfer uses 2^xfer lanes at the address offset within the bus
  // word, mirrored for big-endian. Lanes beyond the bus width never enable.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] xfer,
                                                     input logic [1:0] bus,
                                                     input logic [2:0] addr_lo,
                                                     input logic       big_end);
    logic [MAX_LANES-1:0] m;
    int bus_b;
    int xb;
    int off;
    int lo;
    bus_b = 1 << bus;
    xb    = 1 << xfer;
    if (xfer > bus) begin
      lo = 0;
      xb = bus_b;
    end else begin
      off = int'(addr_lo) & (bus_b - 1);
      lo  = big_end ? (bus_b - xb - off) : off;
    end
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (i >= lo) && (i < lo + xb) && (i < bus_b);
    end
    return m;
  endfunction

endpackage

// File: rtl/smc_be_decode.sv
// Combinational byte-lane decoder: (xfer, bus, offset, endian) -> active-low
// byte enables for one external sub-access.
module smc_be_decode
  import smc_addr_seq_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic [1:0]            xfer_size_i,
  input  logic [1:0]            bus_size_i,
  input  logic [2:0]            offset_i,
  input  logic                  big_endian_i,
  output logic [DATA_BYTES-1:0] n_be_o
);

  logic [MAX_LANES-1:0] mask;
  logic                 unused_mask_bits;

  assign mask             = lane_mask(xfer_size_i, bus_size_i, offset_i, big_endian_i);
  assign n_be_o           = ~mask[DATA_BYTES-1:0];
  assign unused_mask_bits = ^mask;

endmodule

// File: rtl/smc_addr_seq.sv
// SMC address/chip-select/byte-enable sequencer: splits one AHB access into
// 1..N external sub-accesses. Build with SMC_ADDR_SEQ_BIGEND_EN to honour big_endian.
module smc_addr_seq
  import smc_addr_seq_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_CS     = 4,
  parameter int DATA_BYTES = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  valid_access,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [NUM_CS-1:0]     cs,
  input  logic [1:0]            xfer_size,
  input  logic [1:0]            bus_size,
  input  logic                  big_endian,
  input  logic                  acc_done,
  output logic                  accept,
  output logic                  busy,
  output logic                  last,
  output logic                  size_err,
  output logic [ADDR_W-1:0]     smc_addr,
  output logic [NUM_CS-1:0]     smc_n_cs,
  output logic [DATA_BYTES-1:0] smc_n_be
);

  state_e                state_q, state_d;
  logic [2:0]            rem_q, rem_d;
  logic [2:0]            n_m1_q, n_m1_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [1:0]            bus_q, bus_d;
  logic                  big_q, big_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_CS-1:0]     n_cs_q, n_cs_d;
  logic [DATA_BYTES-1:0] n_be_q, n_be_d;
  logic                  last_q, last_d;
  logic                  size_err_q, size_err_d;

  logic                  req_big;
  logic                  sizes_legal;
  logic                  cs_onehot;
  logic                  window;
  logic                  req_wide;
  logic [1:0]            req_diff;
  logic [2:0]            req_n_m1;
  logic [ADDR_W-1:0]     req_base;
  logic [DATA_BYTES-1:0] req_n_be;
  logic [2:0]            rem_next;

`ifdef SMC_ADDR_SEQ_BIGEND_EN
  assign req_big = big_endian;
`else
  logic unused_big_endian;
  assign unused_big_endian = big_endian;
  assign req_big           = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [2:0]        idx,
                                                  input logic [1:0]        bsz);
    return base + (ADDR_W'(idx) << bsz);
  endfunction

  assign sizes_legal = ((4'd1 << xfer_size) <= 4'(DATA_BYTES)) &&
                       ((4'd1 << bus_size)  <= 4'(DATA_BYTES));
  assign cs_onehot   = (cs != '0) && ((cs & (cs - NUM_CS'(1))) == '0);
  // A new request may only be taken when idle or as the final beat completes.
  assign window      = (state_q == ST_IDLE) || (acc_done && last_q);
  assign accept      = valid_access && window && sizes_legal && cs_onehot && !sys_reset;

  assign req_wide = xfer_size > bus_size;
  assign req_diff = xfer_size - bus_size;
  assign req_n_m1 = req_wide ? 3'((4'd1 << req_diff) - 4'd1) : 3'd0;
  assign req_base = req_wide ? (addr & ({ADDR_W{1'b1}} << xfer_size)) : addr;
  assign rem_next = rem_q - 3'd1;

  smc_be_decode #(
    .DATA_BYTES (DATA_BYTES)
  ) u_be_decode (
    .xfer_size_i  (xfer_size),
    .bus_size_i   (bus_size),
    .offset_i     (addr[2:0]),
    .big_endian_i (req_big),
    .n_be_o       (req_n_be)
  );

  // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    n_m1_d     = n_m1_q;
    base_d     = base_q;
    bus_d      = bus_q;
    big_d      = big_q;
    addr_d     = addr_q;
    n_cs_d     = n_cs_q;
    n_be_d     = n_be_q;
    last_d     = last_q;
    size_err_d = valid_access && window && !(sizes_legal && cs_onehot);

    if (accept) begin
      state_d = ST_ACTIVE;
      rem_d   = req_n_m1;
      n_m1_d  = req_n_m1;
      base_d  = req_base;
      bus_d   = bus_size;
      big_d   = req_big;
      addr_d  = beat_addr(req_base, req_big ? 3'd0 : req_n_m1, bus_size);
      n_cs_d  = ~cs;
      n_be_d  = req_n_be;
      last_d  = (req_n_m1 == 3'd0);
    end else if (state_q == ST_ACTIVE && acc_done) begin
      if (last_q) begin
        state_d = ST_IDLE;
        n_cs_d  = '1;
        n_be_d  = '1;
        last_d  = 1'b0;
      end else begin
        rem_d  = rem_next;
        addr_d = beat_addr(base_q, big_q ? (n_m1_q - rem_next) : rem_next, bus_q);
        last_d = (rem_next == 3'd0);
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      n_m1_q     <= '0;
      base_q     <= '0;
      bus_q      <= '0;
      big_q      <= 1'b0;
      addr_q     <= '0;
      n_cs_q     <= '1;
      n_be_q     <= '1;
      last_q     <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      n_m1_q     <= n_m1_d;
      base_q     <= base_d;
      bus_q      <= bus_d;
      big_q      <= big_d;
      addr_q     <= addr_d;
      n_cs_q     <= n_cs_d;
      n_be_q     <= n_be_d;
      last_q     <= last_d;
      size_err_q <= size_err_d;
    end
  end

  assign busy     = (state_q == ST_ACTIVE);
  assign last     = last_q;
  assign size_err = size_err_q;
  assign smc_addr = addr_q;
  assign smc_n_cs = n_cs_q;
  assign smc_n_be = n_be_q;

endmodule
